// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer.
// Issues one instruction-memory request at a time, presents the returned
// word downstream with its address, and handles branch/jump redirects.
// A redirect taken while a request is outstanding marks that request as
// stale so its returning data is dropped and fetching restarts at the target.

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    input  logic        stall_i,
    input  logic        br_valid_i,
    input  logic [15:0] br_off_i,
    input  logic        jmp_valid_i,
    input  logic [25:0] jmp_idx_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t      state_r;
    logic        flush_r;
    logic        redir_s;
    logic [31:0] target_s;

    // Branch target: word offset relative to the instruction after inst_pc.
    function automatic logic [31:0] br_target(input logic [31:0] base,
                                               input logic [15:0] off);
        br_target = base + 32'd4 + {{14{off[15]}}, off, 2'b00};
    endfunction

    // Jump target: keep the 256 MB region of the current instruction.
    function automatic logic [31:0] jmp_target(input logic [31:0] base,
                                                input logic [25:0] idx);
        jmp_target = {base[31:28], idx, 2'b00};
    endfunction

    // Select the redirect target; a jump has priority over a branch.
    always_comb begin
        redir_s  = 1'b0;
        target_s = 32'd0;
        if (jmp_valid_i) begin
            redir_s  = 1'b1;
            target_s = jmp_target(inst_pc_o, jmp_idx_i);
        end else if (br_valid_i) begin
            redir_s  = 1'b1;
            target_s = br_target(inst_pc_o, br_off_i);
        end else begin
            redir_s  = 1'b0;
            target_s = 32'd0;
        end
    end

    // Fetch FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pc_o         <= RESET_PC;
            imem_addr_o  <= RESET_PC;
            imem_req_o   <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= 32'd0;
            inst_pc_o    <= 32'd0;
            flush_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (redir_s) begin
                        pc_o <= target_s;
                    end else if (run_i) begin
                        state_r     <= REQ;
                        imem_req_o  <= 1'b1;
                        imem_addr_o <= pc_o;
                    end
                end
                REQ: begin
                    if (imem_ack_i && redir_s) begin
                        // Returning data belongs to the old path: drop it
                        // and restart directly at the target.
                        pc_o        <= target_s;
                        imem_addr_o <= target_s;
                        flush_r     <= 1'b0;
                    end else if (imem_ack_i && flush_r) begin
                        // Stale response from before an earlier redirect.
                        flush_r     <= 1'b0;
                        imem_addr_o <= pc_o;
                    end else if (imem_ack_i) begin
                        state_r      <= OUT;
                        imem_req_o   <= 1'b0;
                        inst_valid_o <= 1'b1;
                        inst_o       <= imem_rdata_i;
                        inst_pc_o    <= imem_addr_o;
                        pc_o         <= imem_addr_o + 32'd4;
                    end else if (redir_s) begin
                        // Request address must stay put until the ack.
                        pc_o    <= target_s;
                        flush_r <= 1'b1;
                    end
                end
                OUT: begin
                    if (redir_s) begin
                        inst_valid_o <= 1'b0;
                        pc_o         <= target_s;
                        if (run_i) begin
                            state_r     <= REQ;
                            imem_req_o  <= 1'b1;
                            imem_addr_o <= target_s;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (!stall_i) begin
                        inst_valid_o <= 1'b0;
                        if (run_i) begin
                            state_r     <= REQ;
                            imem_req_o  <= 1'b1;
                            imem_addr_o <= pc_o;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    imem_req_o   <= 1'b0;
                    inst_valid_o <= 1'b0;
                    flush_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// Inputs change 1 time unit after each rising edge; outputs are checked there.

module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run_i;
    logic        stall_i;
    logic        br_valid_i;
    logic [15:0] br_off_i;
    logic        jmp_valid_i;
    logic [25:0] jmp_idx_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [31:0] pc_o;

    int n_checks;
    int n_fail;

    fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run_i),
        .stall_i      (stall_i),
        .br_valid_i   (br_valid_i),
        .br_off_i     (br_off_i),
        .jmp_valid_i  (jmp_valid_i),
        .jmp_idx_i    (jmp_idx_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .pc_o         (pc_o)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Complete one fetch from REQ: ack with data, land in OUT.
    task automatic do_ack(input logic [31:0] data);
        imem_ack_i   = 1'b1;
        imem_rdata_i = data;
        step();
        imem_ack_i   = 1'b0;
    endtask

    // Stimulus and checks.
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        run_i        = 1'b0;
        stall_i      = 1'b0;
        br_valid_i   = 1'b0;
        br_off_i     = 16'h0000;
        jmp_valid_i  = 1'b0;
        jmp_idx_i    = 26'h0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'h0;
        step();
        step();
        check_eq("rst_req",   {31'd0, imem_req_o},   32'd0);
        check_eq("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("rst_pc",    pc_o,        32'h0000_3000);
        check_eq("rst_addr",  imem_addr_o, 32'h0000_3000);
        check_eq("rst_inst",  inst_o,      32'h0);
        check_eq("rst_ipc",   inst_pc_o,   32'h0);

        // First fetch
        rst_n = 1'b1;
        run_i = 1'b1;
        step();
        check_eq("f1_req",  {31'd0, imem_req_o}, 32'd1);
        check_eq("f1_addr", imem_addr_o, 32'h0000_3000);
        do_ack(32'hAABB_CCDD);
        check_eq("f1_valid", {31'd0, inst_valid_o}, 32'd1);
        check_eq("f1_inst",  inst_o,    32'hAABB_CCDD);
        check_eq("f1_ipc",   inst_pc_o, 32'h0000_3000);
        check_eq("f1_pc",    pc_o,      32'h0000_3004);
        check_eq("f1_reqlo", {31'd0, imem_req_o}, 32'd0);

        // Stall for three cycles
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_valid", {31'd0, inst_valid_o}, 32'd1);
            check_eq("stall_inst",  inst_o,    32'hAABB_CCDD);
            check_eq("stall_ipc",   inst_pc_o, 32'h0000_3000);
        end
        stall_i = 1'b0;
        step();
        check_eq("rel_req",   {31'd0, imem_req_o},   32'd1);
        check_eq("rel_addr",  imem_addr_o, 32'h0000_3004);
        check_eq("rel_valid", {31'd0, inst_valid_o}, 32'd0);

        // Walk sequentially up to inst_pc = 3010
        do_ack(32'h1111_0004); step();
        do_ack(32'h1111_0008); step();
        do_ack(32'h1111_000C); step();
        do_ack(32'h1111_0010);
        check_eq("seq_ipc", inst_pc_o, 32'h0000_3010);
        check_eq("seq_pc",  pc_o,      32'h0000_3014);
        step();
        check_eq("seq_addr", imem_addr_o, 32'h0000_3014);

        // Branch while REQ waits: 3010 + 4 - 8 = 300C
        br_valid_i = 1'b1;
        br_off_i   = 16'hFFFE;
        step();
        br_valid_i = 1'b0;
        check_eq("brq_pc",   pc_o,        32'h0000_300C);
        check_eq("brq_addr", imem_addr_o, 32'h0000_3014);
        check_eq("brq_req",  {31'd0, imem_req_o}, 32'd1);
        do_ack(32'hDEAD_BEEF);
        check_eq("drop_valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("drop_req",   {31'd0, imem_req_o},   32'd1);
        check_eq("drop_addr",  imem_addr_o, 32'h0000_300C);
        do_ack(32'h2222_300C);
        check_eq("tgt_valid", {31'd0, inst_valid_o}, 32'd1);
        check_eq("tgt_inst",  inst_o,    32'h2222_300C);
        check_eq("tgt_ipc",   inst_pc_o, 32'h0000_300C);
        check_eq("tgt_pc",    pc_o,      32'h0000_3010);
        step();
        do_ack(32'h2222_3010);
        check_eq("j_ipc", inst_pc_o, 32'h0000_3010);

        // Jump and branch together in OUT, run low -> IDLE
        run_i       = 1'b0;
        jmp_valid_i = 1'b1;
        jmp_idx_i   = 26'h000_0100;
        br_valid_i  = 1'b1;
        br_off_i    = 16'h0001;
        step();
        jmp_valid_i = 1'b0;
        br_valid_i  = 1'b0;
        check_eq("jmp_pc",    pc_o, 32'h0000_0400);
        check_eq("jmp_valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("jmp_req",   {31'd0, imem_req_o},   32'd0);

        // Branch in IDLE: 3010 + 4 + 4 = 3018, stay idle
        br_valid_i = 1'b1;
        br_off_i   = 16'h0001;
        step();
        br_valid_i = 1'b0;
        check_eq("idle_br_pc",  pc_o, 32'h0000_3018);
        check_eq("idle_br_req", {31'd0, imem_req_o}, 32'd0);

        // Redirect coinciding with ack: 3010 + 4 + 8 = 301C
        run_i = 1'b1;
        step();
        check_eq("co_addr0", imem_addr_o, 32'h0000_3018);
        br_valid_i = 1'b1;
        br_off_i   = 16'h0002;
        do_ack(32'h3333_3018);
        br_valid_i = 1'b0;
        check_eq("co_valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("co_addr",  imem_addr_o, 32'h0000_301C);
        check_eq("co_pc",    pc_o,        32'h0000_301C);
        check_eq("co_req",   {31'd0, imem_req_o}, 32'd1);
        step();
        check_eq("co_valid2", {31'd0, inst_valid_o}, 32'd0);
        do_ack(32'h4444_301C);
        check_eq("co_nofl_valid", {31'd0, inst_valid_o}, 32'd1);
        check_eq("co_nofl_inst",  inst_o,    32'h4444_301C);
        check_eq("co_nofl_ipc",   inst_pc_o, 32'h0000_301C);

        // Jump in OUT while stalled, run high -> REQ at target
        stall_i     = 1'b1;
        jmp_valid_i = 1'b1;
        jmp_idx_i   = 26'h3FF_FFFF;
        step();
        jmp_valid_i = 1'b0;
        stall_i     = 1'b0;
        check_eq("oj_valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("oj_req",   {31'd0, imem_req_o},   32'd1);
        check_eq("oj_addr",  imem_addr_o, 32'h0FFF_FFFC);
        check_eq("oj_pc",    pc_o,        32'h0FFF_FFFC);

        // Reset mid-REQ, then a late ack must be ignored
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run_i = 1'b0;
        do_ack(32'h5555_5555);
        check_eq("rr_valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("rr_req",   {31'd0, imem_req_o},   32'd0);
        check_eq("rr_pc",    pc_o,   32'h0000_3000);
        check_eq("rr_inst",  inst_o, 32'h0);
        step();
        check_eq("rr_valid2", {31'd0, inst_valid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
